// File: rtl/reg_file_2r1w.sv
// ============================================================================
//  Module   : reg_file_2r1w
//  Purpose  : 32-entry, two-read / one-write register file. Register 0 always
//             reads zero. An optional write-through bypass forwards a
//             same-cycle write onto the read ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_mem [c_DEPTH];
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;

    // A write is only effective out of reset and to a nonzero index; the same
    // qualifier gates the bypass, so r0 and reset cycles never forward.
    assign w_wr_en = !reset && reg_write && (write_reg != '0);

    // Entry 0 has no storage at all.
    assign w_mem[0] = '0;

    for (genvar i = 1; i < c_DEPTH; i++) begin : g_entry
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else if (w_wr_en && (write_reg == ADDR_W'(i))) begin
                r_q <= write_data;
            end
        end

        assign w_mem[i] = r_q;
    end

    assign w_stored1 = w_mem[read_reg1];
    assign w_stored2 = w_mem[read_reg2];

    if (BYPASS) begin : g_bypass
        logic w_fwd1;
        logic w_fwd2;

        assign w_fwd1     = w_wr_en && (write_reg == read_reg1);
        assign w_fwd2     = w_wr_en && (write_reg == read_reg2);
        assign read_data1 = w_fwd1 ? write_data : w_stored1;
        assign read_data2 = w_fwd2 ? write_data : w_stored2;
    end else begin : g_no_bypass
        assign read_data1 = w_stored1;
        assign read_data2 = w_stored2;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
// ============================================================================
//  Module   : tb_reg_file_2r1w
//  Purpose  : Self-checking bench for reg_file_2r1w (bypass and no-bypass
//             instances) against an array-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_2r1w;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_write;
    logic [AW-1:0] wr_direct;
    logic [AW-1:0] mux_a;
    logic [AW-1:0] mux_b;
    logic          mux_op;
    logic          mux_en;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

    logic [DW-1:0] ref_mem [32];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    // Destination-register 2:1 mux (rt/rd select) feeding the write index.
    assign write_reg = mux_en ? (mux_op ? mux_b : mux_a) : wr_direct;

    reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    reg_file_2r1w #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] idx, input bit byp);
        if (idx == 0) return '0;
        if (byp && !reset && reg_write && write_reg != 0 && write_reg == idx) return write_data;
        return ref_mem[idx];
    endfunction

    task automatic check_reads(input string tag);
        chk({tag, ".b1"}, rd1_b, model_rd(read_reg1, 1'b1));
        chk({tag, ".b2"}, rd2_b, model_rd(read_reg2, 1'b1));
        chk({tag, ".n1"}, rd1_n, model_rd(read_reg1, 1'b0));
        chk({tag, ".n2"}, rd2_n, model_rd(read_reg2, 1'b0));
    endtask

    // Checks before the edge, applies the edge to the model, checks after it.
    task automatic tick(input string tag);
        #2;
        check_reads({tag, ".pre"});
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        end else if (reg_write && write_reg != 0) begin
            ref_mem[write_reg] = write_data;
        end
        #1;
        check_reads({tag, ".post"});
    endtask

    task automatic drive(input logic rst_v, input logic we, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        reset      = rst_v;
        reg_write  = we;
        wr_direct  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        mux_en = 1'b0; mux_a = '0; mux_b = '0; mux_op = 1'b0;
        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        @(posedge clk);
        #1;

        // 1. Reset clears everything
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, '0, AW'(i), AW'(31 - i));
            tick($sformatf("rst%0d", i));
            chk($sformatf("rst_zero%0d", i), rd1_b, 32'd0);
        end

        // 2. Basic write / read
        drive(1'b0, 1'b1, 5'd2, 32'd2, 5'd0, 5'd0); tick("wr2");
        drive(1'b0, 1'b1, 5'd3, 32'd3, 5'd0, 5'd0); tick("wr3");
        drive(1'b0, 1'b0, 5'd0, '0, 5'd2, 5'd3);    tick("rd23");
        chk("s2_rd1", rd1_n, 32'd2);
        chk("s2_rd2", rd2_n, 32'd3);
        drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd2);    tick("rd32");
        chk("s2_swap1", rd1_n, 32'd3);
        chk("s2_swap2", rd2_n, 32'd2);

        // 3. r0 immutable, even under bypass
        drive(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        #2;
        chk("r0_pre", rd1_b, 32'd0);
        tick("r0");
        chk("r0_post", rd1_b, 32'd0);

        // 4. Bypass
        drive(1'b0, 1'b1, 5'd5, 32'd7, 5'd0, 5'd0); tick("wr5");
        drive(1'b0, 1'b1, 5'd5, 32'd9, 5'd5, 5'd5);
        #2;
        chk("byp_b1", rd1_b, 32'd9);
        chk("byp_b2", rd2_b, 32'd9);
        chk("byp_n1", rd1_n, 32'd7);
        chk("byp_n2", rd2_n, 32'd7);
        tick("byp");
        chk("byp_post_n1", rd1_n, 32'd9);
        chk("byp_post_b2", rd2_b, 32'd9);

        // 5. Write disable, then reset beats write
        drive(1'b0, 1'b0, 5'd4, 32'd1, 5'd4, 5'd2); tick("wdis");
        chk("wdis_r4", rd1_n, 32'd0);
        drive(1'b1, 1'b1, 5'd4, 32'd5, 5'd4, 5'd2); tick("rstwr");
        drive(1'b0, 1'b0, 5'd0, '0, 5'd4, 5'd2);    tick("rstchk");
        chk("rst_r4", rd1_b, 32'd0);
        chk("rst_r2", rd2_b, 32'd0);
        drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd5);    tick("rstchk2");
        chk("rst_r3", rd1_b, 32'd0);
        chk("rst_r5", rd2_b, 32'd0);

        // 6. Destination mux drives write_reg
        mux_en = 1'b1; mux_a = 5'd2; mux_b = 5'd3; mux_op = 1'b0;
        drive(1'b0, 1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0); tick("mux0");
        mux_op = 1'b1;
        drive(1'b0, 1'b1, 5'd0, 32'h5A5A5A5A, 5'd0, 5'd0); tick("mux1");
        mux_en = 1'b0;
        drive(1'b0, 1'b0, 5'd0, '0, 5'd2, 5'd3);           tick("muxrd");
        chk("mux_r2", rd1_n, 32'hA5A5A5A5);
        chk("mux_r3", rd2_n, 32'h5A5A5A5A);

        // Randomized traffic, biased toward index collisions
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wr;
            wr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), wr, DW'($urandom()),
                  ($urandom_range(0, 2) == 0) ? wr : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wr : AW'($urandom_range(0, 31)));
            tick($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry general-purpose register file, two read ports and one write port. It sits directly downstream of the 5-bit 2:1 destination-register mux (rt/rd select).
- The mux output drives the write_reg port. The ALU/memory write-back data drives write_data.
- Register 0 reads as constant zero.
- An optional write-through bypass lets a same-cycle write be seen on the read ports.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- BYPASS, 1, when 1 a same-cycle write to an addressed register is forwarded to read data; when 0 reads return the stored value only.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable for the current cycle.
- write_reg  input  ADDR_W  destination register index (from the 5-bit destination mux).
- write_data  input  DATA_W  value to write.
- read_reg1  input  ADDR_W  read port 1 index.
- read_reg2  input  ADDR_W  read port 2 index.
- read_data1  output  DATA_W  read port 1 data.
- read_data2  output  DATA_W  read port 2 data.

Behaviour:
- Interface (already decided): one clock, clk. Reset, named reset, is synchronous and active-high.
- Storage: 32 x DATA_W registers.
- Reset:
  - On a rising clk edge with reset=1, all 32 registers clear to 0. No other state exists.
  - Reset has priority over reg_write in the same cycle, so the write is dropped.
  - While reset=1, the bypass is suppressed and read_data1/2 show stored contents (0 after the first reset edge).
  - Reset mid-operation (between writes) discards all prior contents at that edge.
- Write:
  - On a rising edge with reset=0, reg_write=1 and write_reg!=0, mem[write_reg] <= write_data.
  - Writes to index 0 are ignored and mem[0] stays 0.
  - reg_write=0 means no state change, whatever write_reg/write_data hold.
- Read:
  - Combinational, zero latency: read_dataN = mem[read_regN].
  - read_regN==0 always yields 0, including under bypass.
- Bypass, when BYPASS=1:
  - Condition: reset=0, reg_write=1, write_reg!=0 and write_reg==read_regN.
  - When it holds, read_dataN = write_data in the same cycle, before the edge.
  - Both ports may bypass at once when read_reg1==read_reg2==write_reg.
- BYPASS=0: read_dataN shows the old value until the edge, then the new value.
- Simultaneous events:
  - Two reads of the same index return identical data.
  - A write and a read to different indices do not interact.
  - Back-to-back writes to the same index: last write wins.
- Width rules:
  - write_data is stored unmodified. No sign/zero extension is done here.
  - Indices are full ADDR_W; no wrap-around occurs, since every 5-bit value is a legal index.
- Outputs have no registered reset value of their own; they are pure functions of storage, the read indices and the bypass condition.

Test Plan:
1. Reset: hold reset=1 for 1 edge, then read r0..r31 on both ports -> every read_data1/2 = 0.
2. Basic write/read:
   - Write r2=32'd2, then r3=32'd3 on consecutive edges.
   - Set read_reg1=2, read_reg2=3 -> read_data1=2, read_data2=3.
   - Then swap the indices -> 3, 2.
3. r0 immutable: reg_write=1, write_reg=0, write_data=32'hDEADBEEF, one edge; read_reg1=0 -> read_data1=0, both before and after the edge, with BYPASS=1.
4. Bypass:
   - r5 holds 7. Drive reg_write=1, write_reg=5, write_data=9, read_reg1=read_reg2=5.
   - Before the edge: both reads = 9 (BYPASS=1) or 7 (BYPASS=0).
   - After the edge: both reads = 9.
5. Write disable and priority:
   - reg_write=0, write_reg=4, write_data=1 -> r4 unchanged (0).
   - Then reset=1 together with reg_write=1, write_reg=4, write_data=5 -> after the edge r4=0, and r2/r3 from scenario 2 are also 0.
6. Mux integration:
   - Instantiate the 5-bit 2:1 mux with a=2, b=3 driving write_reg, and write 32'hA5A5A5A5 with op=0, then 32'h5A5A5A5A with op=1.
   - Result: r2=A5A5A5A5, r3=5A5A5A5A.
